// File: rtl/ltc2668_spi_master.sv
// ---------------------------------------------------------------------------
// ltc2668_spi_master
// Single-frame SPI master (mode 0) for the LTC2668 16-channel DAC. Each
// accepted request sends one 24-bit frame {cmd, addr, data}, MSB first, and
// captures the 24-bit SDO echo. SCK is a register in the system clock domain
// that toggles at half-period boundaries. It is not a derived clock.
//
// Ports
//   clock_in  system clock (rising edge)
//   reset     asynchronous, active-high reset
//   start     request, sampled only while idle
//   cmd       command nibble  -> frame[23:20]
//   addr      address nibble  -> frame[19:16]
//   data      DAC code        -> frame[15:0]
//   busy      high from the cycle after acceptance through the done cycle
//   done      one-cycle completion pulse
//   rd_data   SDO word captured during the last completed frame
//   sck       serial clock, idles low
//   cs_n      chip select, active low
//   sdi       serial data to the DAC
//   sdo       serial data from the DAC
// ---------------------------------------------------------------------------
module ltc2668_spi_master #(
   parameter int HALF_PERIOD = 7,
   parameter int CS_SETUP    = 2,
   parameter int FRAME_BITS  = 24
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  cmd,
   input  logic [3:0]  addr,
   input  logic [15:0] data,
   output logic        busy,
   output logic        done,
   output logic [23:0] rd_data,
   output logic        sck,
   output logic        cs_n,
   output logic        sdi,
   input  logic        sdo
);

   localparam int HP_W = $clog2(HALF_PERIOD + 1);
   localparam int CS_W = $clog2(CS_SETUP + 1);

   localparam logic [HP_W-1:0] HP_LAST  = HP_W'(HALF_PERIOD - 1);
   localparam logic [CS_W-1:0] CS_LAST  = CS_W'(CS_SETUP - 1);
   localparam logic [4:0]      BIT_LAST = 5'(FRAME_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      r_state;
   logic [HP_W-1:0] r_hp_cnt;
   logic [CS_W-1:0] r_cs_cnt;
   logic [4:0]      r_bit_cnt;
   logic [23:0]     r_tx_shift;
   logic [23:0]     r_rx_shift;
   logic [23:0]     r_rd_data;
   logic            r_sck;
   logic            r_cs_n;
   logic            r_sdi;
   logic            r_busy;
   logic            r_done;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_hp_cnt   <= '0;
         r_cs_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rd_data  <= '0;
         r_sck      <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sdi      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               r_sdi  <= 1'b0;
               r_sck  <= 1'b0;
               if (start) begin
                  // sdi is loaded with the MSB now, so it is stable for the
                  // whole setup window before the first rising edge.
                  r_tx_shift <= {cmd, addr, data};
                  r_sdi      <= cmd[3];
                  r_cs_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_cs_cnt   <= '0;
                  r_state    <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (r_cs_cnt == CS_LAST) begin
                  r_cs_cnt  <= '0;
                  r_hp_cnt  <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= S_SHIFT;
               end else begin
                  r_cs_cnt <= r_cs_cnt + 1'b1;
               end
            end

            S_SHIFT: begin
               if (r_hp_cnt == HP_LAST) begin
                  r_hp_cnt <= '0;
                  if (!r_sck) begin
                     // Rising edge: the DAC samples sdi. SDO is captured on the same edge.
                     r_sck      <= 1'b1;
                     r_rx_shift <= {r_rx_shift[22:0], sdo};
                  end else begin
                     // Falling edge: present the next bit. Zeros fill from the LSB.
                     r_sck      <= 1'b0;
                     r_tx_shift <= {r_tx_shift[22:0], 1'b0};
                     r_sdi      <= r_tx_shift[22];
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == BIT_LAST) begin
                        r_cs_cnt <= '0;
                        r_state  <= S_HOLD;
                     end
                  end
               end else begin
                  r_hp_cnt <= r_hp_cnt + 1'b1;
               end
            end

            S_HOLD: begin
               if (r_cs_cnt == CS_LAST) begin
                  r_cs_cnt  <= '0;
                  r_cs_n    <= 1'b1;
                  r_done    <= 1'b1;
                  r_sdi     <= 1'b0;
                  r_rd_data <= r_rx_shift;
                  r_state   <= S_DONE;
               end else begin
                  r_cs_cnt <= r_cs_cnt + 1'b1;
               end
            end

            S_DONE: begin
               // busy drops here. start is not sampled in this cycle.
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_cs_n  <= 1'b1;
               r_sck   <= 1'b0;
               r_sdi   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rd_data = r_rd_data;
   assign sck     = r_sck;
   assign cs_n    = r_cs_n;
   assign sdi     = r_sdi;

endmodule

// File: tb/tb_ltc2668_spi_master.sv
// ---------------------------------------------------------------------------
// tb_ltc2668_spi_master
// Instance 0 uses the default timing. Instance 1 uses HALF_PERIOD=1 and
// CS_SETUP=1. A bus monitor rebuilds every frame from the pins: the SDI word,
// the SCK edge spacing, the cs_n window and the done pulse. It also acts as
// the DAC by driving SDO from a reference word. A frame is expected to carry
// {cmd,addr,data} and return the driven SDO word in rd_data.
// ---------------------------------------------------------------------------
module tb_ltc2668_spi_master;

   localparam int HP0 = 7;
   localparam int CS0 = 2;
   localparam int HP1 = 1;
   localparam int CS1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  start = '0;
   logic [3:0]  cmd  [2] = '{default: '0};
   logic [3:0]  addr [2] = '{default: '0};
   logic [15:0] data [2] = '{default: '0};
   logic [1:0]  sdo = '0;
   logic [1:0]  busy, done, sck, cs_n, sdi;
   logic [23:0] rd_data [2];

   always #5 clk = ~clk;

   ltc2668_spi_master #(.HALF_PERIOD(HP0), .CS_SETUP(CS0), .FRAME_BITS(24)) u_dut0 (
      .clock_in(clk), .reset(rst), .start(start[0]), .cmd(cmd[0]), .addr(addr[0]),
      .data(data[0]), .busy(busy[0]), .done(done[0]), .rd_data(rd_data[0]),
      .sck(sck[0]), .cs_n(cs_n[0]), .sdi(sdi[0]), .sdo(sdo[0]));

   ltc2668_spi_master #(.HALF_PERIOD(HP1), .CS_SETUP(CS1), .FRAME_BITS(24)) u_dut1 (
      .clock_in(clk), .reset(rst), .start(start[1]), .cmd(cmd[1]), .addr(addr[1]),
      .data(data[1]), .busy(busy[1]), .done(done[1]), .rd_data(rd_data[1]),
      .sck(sck[1]), .cs_n(cs_n[1]), .sdi(sdi[1]), .sdo(sdo[1]));

   function automatic int hp_of(input int g);
      return (g == 0) ? HP0 : HP1;
   endfunction

   function automatic int cs_of(input int g);
      return (g == 0) ? CS0 : CS1;
   endfunction

   // ---------------- bus monitor / DAC model ----------------
   int          cyc = 0;
   int          cs_fall_c [2] = '{default: 0};
   int          cs_rise_c [2] = '{default: 0};
   int          edge_c    [2] = '{default: 0};
   int          rises     [2] = '{default: 0};
   int          falls     [2] = '{default: 0};
   int          frames    [2] = '{default: 0};
   int          dones     [2] = '{default: 0};
   int          tim_err   [2] = '{default: 0};
   int          glitch    [2] = '{default: 0};
   int          done_err  [2] = '{default: 0};
   int          rise_err  [2] = '{default: 0};
   int          cs_low    [2] = '{default: 0};
   int          last_rises[2] = '{default: 0};
   int          gap_min   [2] = '{default: 1000000};
   int          gap_max   [2] = '{default: 0};
   logic [23:0] sdi_acc   [2] = '{default: '0};
   logic [23:0] last_sdi  [2] = '{default: '0};
   logic [23:0] sdo_word  [2] = '{default: '0};
   logic        prev_sck  [2] = '{default: 1'b0};
   logic        prev_cs   [2] = '{default: 1'b1};

   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            prev_sck[g] = 1'b0;
            prev_cs[g]  = 1'b1;
            sdo[g]      = 1'b0;
         end else begin
            if (prev_cs[g] && !cs_n[g]) begin
               if (frames[g] > 0) begin
                  if (cyc - cs_rise_c[g] < gap_min[g]) gap_min[g] = cyc - cs_rise_c[g];
                  if (cyc - cs_rise_c[g] > gap_max[g]) gap_max[g] = cyc - cs_rise_c[g];
               end
               cs_fall_c[g] = cyc;
               edge_c[g]    = cyc + cs_of(g);
               rises[g]     = 0;
               falls[g]     = 0;
               sdi_acc[g]   = '0;
               sdo[g]       = sdo_word[g][23];
            end
            if (!prev_sck[g] && sck[g]) begin
               if (cyc - edge_c[g] != hp_of(g)) tim_err[g]++;
               edge_c[g]  = cyc;
               rises[g]++;
               sdi_acc[g] = {sdi_acc[g][22:0], sdi[g]};
            end
            if (prev_sck[g] && !sck[g]) begin
               if (cyc - edge_c[g] != hp_of(g)) tim_err[g]++;
               edge_c[g] = cyc;
               falls[g]++;
               sdo[g] = (falls[g] < 24) ? sdo_word[g][23 - falls[g]] : 1'b0;
            end
            if (cs_n[g] && sck[g]) glitch[g]++;
            if (!prev_cs[g] && cs_n[g]) begin
               frames[g]++;
               cs_low[g]     = cyc - cs_fall_c[g];
               cs_rise_c[g]  = cyc;
               last_sdi[g]   = sdi_acc[g];
               last_rises[g] = rises[g];
               if (rises[g] != 24) rise_err[g]++;
               if (!done[g]) done_err[g]++;
               if (cyc - edge_c[g] != cs_of(g)) tim_err[g]++;
               if (cs_low[g] != 2 * cs_of(g) + 48 * hp_of(g)) tim_err[g]++;
            end else if (done[g]) begin
               done_err[g]++;
            end
            if (done[g]) dones[g]++;
            prev_sck[g] = sck[g];
            prev_cs[g]  = cs_n[g];
         end
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic launch(input int g, input logic [3:0] c, input logic [3:0] a,
                         input logic [15:0] d);
      @(posedge clk); #1;
      cmd[g] = c; addr[g] = a; data[g] = d; start[g] = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
      cmd[g]  = 4'($urandom);
      addr[g] = 4'($urandom);
      data[g] = 16'($urandom);
   endtask

   task automatic wait_frames(input int g, input int n, input int budget);
      int k = 0;
      while (frames[g] < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (frames[g] < n) chk("timeout_frames", 32'(frames[g]), 32'(n));
   endtask

   task automatic wait_rises(input int n);
      int k = 0;
      while (rises[0] < n && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      if (rises[0] < n) chk("timeout_rises", 32'(rises[0]), 32'(n));
   endtask

   task automatic frame0(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d,
                         input logic [23:0] so);
      int f0 = frames[0];
      int d0 = dones[0];
      sdo_word[0] = so;
      launch(0, c, a, d);
      chk("busy_after_accept", 32'(busy[0]), 32'd1);
      wait_frames(0, f0 + 1, 800);
      @(posedge clk); #1;
      chk("sdi_word", 32'(last_sdi[0]), 32'({c, a, d}));
      chk("rise_count", 32'(last_rises[0]), 32'd24);
      chk("cs_low_cycles", 32'(cs_low[0]), 32'(2 * CS0 + 48 * HP0));
      chk("done_pulses", 32'(dones[0] - d0), 32'd1);
      chk("rd_data", 32'(rd_data[0]), 32'(so));
      chk("busy_idle", 32'(busy[0]), 32'd0);
   endtask

   initial begin
      logic [23:0] so1;
      int          f0, k;

      // Reset state, asserted between edges.
      #2 rst = 1'b1;
      #1;
      chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
      chk("rst_sck", 32'(sck[0]), 32'd0);
      chk("rst_sdi", 32'(sdi[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_rd_data", 32'(rd_data[0]), 32'd0);
      #20 rst = 1'b0;

      // Directed frame with SDO echo.
      frame0(4'h3, 4'h5, 16'hABCD, 24'h123456);
      repeat (20) @(posedge clk);
      #1 chk("rd_data_hold", 32'(rd_data[0]), 32'h123456);

      // start during the frame and during DONE is ignored.
      f0 = frames[0];
      sdo_word[0] = 24'($urandom);
      launch(0, 4'h3, 4'h5, 16'hABCD);
      wait_rises(8);
      chk("rd_data_hold_mid", 32'(rd_data[0]), 32'h123456);
      cmd[0] = 4'h3; addr[0] = 4'h5; data[0] = 16'hFFFF; start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      k = 0;
      while (!done[0] && k < 800) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_seen", 32'(done[0]), 32'd1);
      start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("ignored_start_frames", 32'(frames[0] - f0), 32'd1);
      chk("ignored_start_sdi", 32'(last_sdi[0]), 32'h35ABCD);
      chk("ignored_start_rises", 32'(last_rises[0]), 32'd24);
      chk("ignored_start_cs_n", 32'(cs_n[0]), 32'd1);

      // Random frames.
      for (int i = 0; i < 4; i++)
         frame0(4'($urandom), 4'($urandom), 16'($urandom), 24'($urandom));

      // Reset mid-frame at bit 10.
      sdo_word[0] = 24'($urandom) | 24'h1;
      launch(0, 4'($urandom), 4'($urandom), 16'($urandom));
      wait_rises(10);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(cs_n[0]), 32'd1);
      chk("midrst_sck", 32'(sck[0]), 32'd0);
      chk("midrst_sdi", 32'(sdi[0]), 32'd0);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_rd_data", 32'(rd_data[0]), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      frame0(4'h2, 4'h0, 16'h8000, 24'($urandom));

      // Fast instance, start held high: back-to-back frames.
      so1 = 24'($urandom);
      sdo_word[1] = so1;
      @(posedge clk); #1;
      cmd[1] = 4'($urandom); addr[1] = 4'($urandom); data[1] = 16'($urandom);
      start[1] = 1'b1;
      wait_frames(1, 3, 1000);
      #1 start[1] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("b2b_frames", 32'(frames[1]), 32'd3);
      chk("b2b_dones", 32'(dones[1]), 32'd3);
      chk("b2b_gap_min", 32'(gap_min[1]), 32'd2);
      chk("b2b_gap_max", 32'(gap_max[1]), 32'd2);
      chk("b2b_rise_err", 32'(rise_err[1]), 32'd0);
      chk("b2b_timing_err", 32'(tim_err[1]), 32'd0);
      chk("b2b_cs_low", 32'(cs_low[1]), 32'(2 * CS1 + 48 * HP1));
      chk("b2b_sdi_word", 32'(last_sdi[1]), 32'({cmd[1], addr[1], data[1]}));
      chk("b2b_rd_data", 32'(rd_data[1]), 32'(so1));
      chk("b2b_done_err", 32'(done_err[1]), 32'd0);

      // Whole-run protocol checks on the default instance.
      chk("timing_err", 32'(tim_err[0]), 32'd0);
      chk("sck_glitch", 32'(glitch[0] + glitch[1]), 32'd0);
      chk("done_err", 32'(done_err[0]), 32'd0);
      chk("rise_err", 32'(rise_err[0]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // The bench stops on its own if the main sequence gets stuck.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
